// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage controller for the LEGv8 pipeline. Each cycle it
// reads the PC register, requests the instruction at that address from
// instruction memory, and captures the returned word into the IF/ID pipeline
// register. It tells the PC register when and what to load, and it absorbs
// hazard stalls, branch redirects and multi-cycle memory latency.
//
// Parameters
//   PC_W        PC / instruction byte-address width
//   INSTR_W     instruction word width
//
// Ports
//   clk          in   single clock, all state updates on rising edge
//   reset_n      in   asynchronous active-low reset
//   current_pc   in   current PC register value
//   next_pc      out  value for the PC register to load
//   PCWrite      out  PC register load enable
//   imem_req     out  instruction-memory request valid
//   imem_addr    out  request byte address (always current_pc)
//   imem_ready   in   memory returns imem_rdata this cycle
//   imem_rdata   in   fetched instruction
//   stall        in   ID stage cannot accept, IF/ID must hold
//   redirect     in   taken branch / flush, go to redirect_pc
//   redirect_pc  in   redirect target
//   ifid_valid   out  IF/ID holds a live instruction
//   ifid_pc      out  PC of the IF/ID instruction
//   ifid_instr   out  IF/ID instruction word
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    current_pc,
    output logic [PC_W-1:0]    next_pc,
    output logic               PCWrite,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetchState_t;

    fetchState_t state_q, state_d;

    logic               ifidValid_q, ifidValid_d;
    logic [PC_W-1:0]    ifidPc_q,    ifidPc_d;
    logic [INSTR_W-1:0] ifidInstr_q, ifidInstr_d;
    logic [INSTR_W-1:0] holdInstr_q, holdInstr_d;
    logic [PC_W-1:0]    redirPc_q,   redirPc_d;

    // Sequential increment wraps naturally at the top of the address space.
    logic [PC_W-1:0]    pcPlus4;

    assign pcPlus4 = current_pc + PC_W'(4);

    // The request address simply tracks the PC register. Because the PC only
    // moves on a cycle where the request completes (or no request is open),
    // address stability during an outstanding request follows for free.
    assign imem_addr  = current_pc;
    assign imem_req   = (state_q == REQ) || (state_q == DISCARD);

    assign ifid_valid = ifidValid_q;
    assign ifid_pc    = ifidPc_q;
    assign ifid_instr = ifidInstr_q;

    // State register plus all datapath registers. Reset is asynchronous so a
    // reset mid-request drops imem_req in the same instant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ifidValid_q <= 1'b0;
            ifidPc_q    <= '0;
            ifidInstr_q <= '0;
            holdInstr_q <= '0;
            redirPc_q   <= '0;
        end else begin
            state_q     <= state_d;
            ifidValid_q <= ifidValid_d;
            ifidPc_q    <= ifidPc_d;
            ifidInstr_q <= ifidInstr_d;
            holdInstr_q <= holdInstr_d;
            redirPc_q   <= redirPc_d;
        end
    end

    // Next-state logic. Redirect is checked before stall everywhere so a
    // flush always wins over a hazard hold.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect && !imem_ready) begin
                    state_d = DISCARD;
                end else if (!redirect && imem_ready && stall) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                if (imem_ready) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath-update logic. PCWrite/next_pc go straight back to
    // the PC register, so next_pc defaults to current_pc whenever no load is
    // requested. HOLD parks a word that arrived while ID was stalled so the
    // memory request can close without losing the instruction; DISCARD
    // remembers a redirect target while waiting out a request whose data
    // must be thrown away.
    always_comb begin
        PCWrite     = 1'b0;
        next_pc     = current_pc;
        ifidValid_d = ifidValid_q;
        ifidPc_d    = ifidPc_q;
        ifidInstr_d = ifidInstr_q;
        holdInstr_d = holdInstr_q;
        redirPc_d   = redirPc_q;

        unique case (state_q)
            IDLE: begin
            end
            REQ: begin
                if (redirect && imem_ready) begin
                    PCWrite     = 1'b1;
                    next_pc     = redirect_pc;
                    ifidValid_d = 1'b0;
                end else if (redirect) begin
                    redirPc_d   = redirect_pc;
                    ifidValid_d = 1'b0;
                end else if (imem_ready && !stall) begin
                    PCWrite     = 1'b1;
                    next_pc     = pcPlus4;
                    ifidValid_d = 1'b1;
                    ifidPc_d    = current_pc;
                    ifidInstr_d = imem_rdata;
                end else if (imem_ready) begin
                    holdInstr_d = imem_rdata;
                end else if (!stall) begin
                    ifidValid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    PCWrite     = 1'b1;
                    next_pc     = redirect_pc;
                    ifidValid_d = 1'b0;
                end else if (!stall) begin
                    PCWrite     = 1'b1;
                    next_pc     = pcPlus4;
                    ifidValid_d = 1'b1;
                    ifidPc_d    = current_pc;
                    ifidInstr_d = holdInstr_q;
                end
            end
            DISCARD: begin
                ifidValid_d = 1'b0;
                if (redirect) begin
                    redirPc_d = redirect_pc;
                end
                if (imem_ready) begin
                    PCWrite = 1'b1;
                    next_pc = redirect ? redirect_pc : redirPc_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed self-checking bench for fetch_unit. A small PC register lives in
// the bench and loads next_pc on PCWrite, as the real pipeline would. Memory
// responses are driven per cycle from the stimulus sequence. Inputs change
// and outputs are sampled shortly after the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    logic               clk;
    logic               reset_n;
    logic [PC_W-1:0]    current_pc;
    logic [PC_W-1:0]    next_pc;
    logic               PCWrite;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               ifid_valid;
    logic [PC_W-1:0]    ifid_pc;
    logic [INSTR_W-1:0] ifid_instr;

    int checkCount;
    int errorCount;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .current_pc  (current_pc),
        .next_pc     (next_pc),
        .PCWrite     (PCWrite),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the pipeline PC register fed by the fetch unit.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current_pc <= '0;
        end else if (PCWrite) begin
            current_pc <= next_pc;
        end
    end

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs just after the falling edge, then lets the
    // combinational outputs settle before the caller samples them.
    task automatic applyStimulus(input logic rdy, input logic [INSTR_W-1:0] data,
                                 input logic stl, input logic redir,
                                 input logic [PC_W-1:0] rpc);
        @(negedge clk);
        imem_ready  = rdy;
        imem_rdata  = data;
        stall       = stl;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset_n     = 1'b0;
        imem_ready  = 1'b0;
        imem_rdata  = '0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid",   32'(ifid_valid), 32'h0);
        checkOutput("rst_pc",      32'(ifid_pc),    32'h0);
        checkOutput("rst_instr",   ifid_instr,      32'h0);
        checkOutput("rst_req",     32'(imem_req),   32'h0);
        checkOutput("rst_pcwrite", 32'(PCWrite),    32'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("idle_req",    32'(imem_req),   32'h0);

        // Sequential zero-wait fetch at 0 and 4.
        applyStimulus(1'b1, 32'h8B020020, 1'b0, 1'b0, '0);
        checkOutput("seq0_req",     32'(imem_req),  32'h1);
        checkOutput("seq0_addr",    32'(imem_addr), 32'h0);
        checkOutput("seq0_pcwrite", 32'(PCWrite),   32'h1);
        checkOutput("seq0_next",    32'(next_pc),   32'h4);
        applyStimulus(1'b1, 32'hF8400041, 1'b0, 1'b0, '0);
        checkOutput("seq1_valid",   32'(ifid_valid), 32'h1);
        checkOutput("seq1_ifpc",    32'(ifid_pc),    32'h0);
        checkOutput("seq1_instr",   ifid_instr,      32'h8B020020);
        checkOutput("seq1_next",    32'(next_pc),    32'h8);
        checkOutput("seq1_pcwrite", 32'(PCWrite),    32'h1);

        // Two wait states at PC 8.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("wait0_ifpc",    32'(ifid_pc),    32'h4);
        checkOutput("wait0_instr",   ifid_instr,      32'hF8400041);
        checkOutput("wait0_addr",    32'(imem_addr),  32'h8);
        checkOutput("wait0_req",     32'(imem_req),   32'h1);
        checkOutput("wait0_pcwrite", 32'(PCWrite),    32'h0);
        checkOutput("wait0_next",    32'(next_pc),    32'h8);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("wait1_valid",   32'(ifid_valid), 32'h0);
        checkOutput("wait1_addr",    32'(imem_addr),  32'h8);
        checkOutput("wait1_pcwrite", 32'(PCWrite),    32'h0);
        applyStimulus(1'b1, 32'hD503201F, 1'b0, 1'b0, '0);
        checkOutput("wait2_valid",   32'(ifid_valid), 32'h0);
        checkOutput("wait2_addr",    32'(imem_addr),  32'h8);
        checkOutput("wait2_pcwrite", 32'(PCWrite),    32'h1);
        checkOutput("wait2_next",    32'(next_pc),    32'hC);

        // Stall while the word at PC 12 returns: park it in HOLD.
        applyStimulus(1'b1, 32'hAA0203E1, 1'b1, 1'b0, '0);
        checkOutput("stl0_valid",   32'(ifid_valid), 32'h1);
        checkOutput("stl0_ifpc",    32'(ifid_pc),    32'h8);
        checkOutput("stl0_instr",   ifid_instr,      32'hD503201F);
        checkOutput("stl0_pcwrite", 32'(PCWrite),    32'h0);
        checkOutput("stl0_next",    32'(next_pc),    32'hC);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0);
            checkOutput("hold_req",     32'(imem_req),  32'h0);
            checkOutput("hold_pcwrite", 32'(PCWrite),   32'h0);
            checkOutput("hold_ifpc",    32'(ifid_pc),   32'h8);
            checkOutput("hold_instr",   ifid_instr,     32'hD503201F);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("rel_pcwrite", 32'(PCWrite),  32'h1);
        checkOutput("rel_next",    32'(next_pc),  32'h10);
        checkOutput("rel_req",     32'(imem_req), 32'h0);

        // Redirect to 0x100 while the request at 16 is outstanding.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 10'h100);
        checkOutput("rdr0_valid",   32'(ifid_valid), 32'h1);
        checkOutput("rdr0_ifpc",    32'(ifid_pc),    32'hC);
        checkOutput("rdr0_instr",   ifid_instr,      32'hAA0203E1);
        checkOutput("rdr0_addr",    32'(imem_addr),  32'h10);
        checkOutput("rdr0_pcwrite", 32'(PCWrite),    32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("dis0_valid",   32'(ifid_valid), 32'h0);
        checkOutput("dis0_req",     32'(imem_req),   32'h1);
        checkOutput("dis0_addr",    32'(imem_addr),  32'h10);
        checkOutput("dis0_pcwrite", 32'(PCWrite),    32'h0);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, '0);
        checkOutput("dis1_valid",   32'(ifid_valid), 32'h0);
        checkOutput("dis1_pcwrite", 32'(PCWrite),    32'h1);
        checkOutput("dis1_next",    32'(next_pc),    32'h100);
        applyStimulus(1'b1, 32'h91000421, 1'b0, 1'b0, '0);
        checkOutput("tgt_valid",   32'(ifid_valid), 32'h0);
        checkOutput("tgt_addr",    32'(imem_addr),  32'h100);
        checkOutput("tgt_req",     32'(imem_req),   32'h1);
        checkOutput("tgt_next",    32'(next_pc),    32'h104);

        // Enter HOLD, then redirect and stall together: redirect wins.
        applyStimulus(1'b1, 32'h12345678, 1'b1, 1'b0, '0);
        checkOutput("h2_ifpc",    32'(ifid_pc),    32'h100);
        checkOutput("h2_instr",   ifid_instr,      32'h91000421);
        checkOutput("h2_pcwrite", 32'(PCWrite),    32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 10'h040);
        checkOutput("rbs_req",     32'(imem_req), 32'h0);
        checkOutput("rbs_pcwrite", 32'(PCWrite),  32'h1);
        checkOutput("rbs_next",    32'(next_pc),  32'h040);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("rbs_valid",   32'(ifid_valid), 32'h0);
        checkOutput("rbs_req2",    32'(imem_req),   32'h1);
        checkOutput("rbs_addr",    32'(imem_addr),  32'h040);

        // Redirect coinciding with ready: data dropped, jump to 0x3FC.
        applyStimulus(1'b1, 32'h0BADF00D, 1'b0, 1'b1, 10'h3FC);
        checkOutput("rr_pcwrite", 32'(PCWrite), 32'h1);
        checkOutput("rr_next",    32'(next_pc), 32'h3FC);

        // Fetch at the top of the address space wraps to 0.
        applyStimulus(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, '0);
        checkOutput("wrap_valid",   32'(ifid_valid), 32'h0);
        checkOutput("wrap_addr",    32'(imem_addr),  32'h3FC);
        checkOutput("wrap_pcwrite", 32'(PCWrite),    32'h1);
        checkOutput("wrap_next",    32'(next_pc),    32'h000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("wrap_ifvalid", 32'(ifid_valid), 32'h1);
        checkOutput("wrap_ifpc",    32'(ifid_pc),    32'h3FC);
        checkOutput("wrap_instr",   ifid_instr,      32'hCAFEF00D);
        checkOutput("wrap_req",     32'(imem_req),   32'h1);
        checkOutput("wrap_addr0",   32'(imem_addr),  32'h000);

        // Reset mid-wait takes effect immediately.
        reset_n = 1'b0;
        #1;
        checkOutput("mrst_valid",   32'(ifid_valid), 32'h0);
        checkOutput("mrst_req",     32'(imem_req),   32'h0);
        checkOutput("mrst_pcwrite", 32'(PCWrite),    32'h0);
        checkOutput("mrst_ifpc",    32'(ifid_pc),    32'h0);
        checkOutput("mrst_instr",   ifid_instr,      32'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput("mrel_idle_req", 32'(imem_req), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("mrel_req",  32'(imem_req),  32'h1);
        checkOutput("mrel_addr", 32'(imem_addr), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
